// File: rtl/spi_line_fetch.sv
// Line prefetcher: reads each scanline's 1bpp bitmap from an SPI ROM (READ 0x03, mode 0)
// one line ahead into a double buffer and serialises the front buffer as a registered pixel.
module spi_line_fetch #(
  parameter int          LINE_BYTES = 20,
  parameter int          PIX_SHIFT  = 2,
  parameter logic [23:0] BASE_ADDR  = 24'h000000,
  parameter int          H_VIEW     = 640,
  parameter int          V_VIEW     = 480,
  parameter int          V_MAX      = 524
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       hmax,
  input  logic       vmax,
  input  logic       visible,
  output logic       spi_cs_n,
  output logic       spi_sclk,
  output logic       spi_mosi,
  input  logic       spi_miso,
  output logic       pixel,
  output logic       busy,
  output logic       overrun
);

  localparam int          N        = LINE_BYTES * 8;
  localparam int          CW       = (N > 1) ? $clog2(N) : 1;
  localparam logic [10:0] LINES    = 11'(V_MAX + 1);
  localparam logic [10:0] V_MAX_L  = 11'(V_MAX);
  localparam logic [10:0] V_VIEW_L = 11'(V_VIEW);
  localparam logic [7:0]  CMD_READ = 8'h03;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;
  localparam logic [1:0] S_ADDR = 2'd2;
  localparam logic [1:0] S_DATA = 2'd3;

  logic [1:0]   r_state;
  logic         r_phase;
  logic [15:0]  r_cnt;
  logic [31:0]  r_tx;
  logic [23:0]  r_addr;
  logic         r_wsel;
  logic [1:0]   r_valid;
  logic         r_cs_n;
  logic         r_sclk;
  logic         r_mosi;
  logic         r_pixel;
  logic         r_overrun;
  logic         r_pend;
  logic         r_pend_lsb;
  logic         r_pend_zero;
  // Bit 0 holds the first ROM bit (leftmost pixel); bytes shift in from the top.
  logic [N-1:0] r_buf [0:1];

  logic [10:0]   w_tgt;
  logic          w_tgt_ok;
  logic          w_abort;
  logic          w_start;
  logic          w_st_lsb;
  logic          w_st_zero;
  logic [23:0]   w_next_addr;
  logic          w_last_bit;
  logic [9:0]    w_col;
  logic [CW-1:0] w_bidx;
  logic          w_in_view;
  logic          w_shift_en;

  // Target line two ahead of the current one, wrapping at the frame end.
  always_comb begin
    w_tgt = {1'b0, vpos} + 11'd2;
    if (vmax) begin
      w_tgt = 11'd1;
    end else if (w_tgt > V_MAX_L) begin
      w_tgt = w_tgt - LINES;
    end else begin
      w_tgt = w_tgt;
    end
  end

  assign w_tgt_ok    = (w_tgt < V_VIEW_L);
  assign w_abort     = hmax && (r_state != S_IDLE);
  assign w_start     = (r_state == S_IDLE) && ((hmax && w_tgt_ok) || r_pend);
  assign w_st_lsb    = (hmax && w_tgt_ok) ? w_tgt[0] : r_pend_lsb;
  assign w_st_zero   = (hmax && w_tgt_ok) ? (w_tgt == 11'd0) : r_pend_zero;
  assign w_next_addr = w_st_zero ? BASE_ADDR : (r_addr + 24'(LINE_BYTES));
  assign w_shift_en  = !reset && !w_abort && !w_start && (r_state == S_DATA) && !r_phase;

  // Last bit of the current FSM segment.
  always_comb begin
    case (r_state)
      S_CMD:   w_last_bit = (r_cnt == 16'd7);
      S_ADDR:  w_last_bit = (r_cnt == 16'd23);
      S_DATA:  w_last_bit = (r_cnt == 16'(N - 1));
      default: w_last_bit = 1'b0;
    endcase
  end

  // SPI sequencer: each bit is a low-sclk cycle with MOSI set up, then a high-sclk cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_cnt       <= 16'd0;
      r_tx        <= 32'd0;
      r_addr      <= BASE_ADDR;
      r_wsel      <= 1'b0;
      r_valid     <= 2'b00;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_overrun   <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_lsb  <= 1'b0;
      r_pend_zero <= 1'b0;
    end else if (w_abort) begin
      // Abort now; the pending target starts next cycle, leaving cs_n high for one cycle.
      r_state     <= S_IDLE;
      r_phase     <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_overrun   <= 1'b1;
      r_pend      <= w_tgt_ok;
      r_pend_lsb  <= w_tgt[0];
      r_pend_zero <= (w_tgt == 11'd0);
    end else if (w_start) begin
      r_state          <= S_CMD;
      r_phase          <= 1'b0;
      r_cnt            <= 16'd0;
      r_tx             <= {CMD_READ, w_next_addr};
      r_mosi           <= CMD_READ[7];
      r_cs_n           <= 1'b0;
      r_sclk           <= 1'b0;
      r_addr           <= w_next_addr;
      r_wsel           <= w_st_lsb;
      r_valid[w_st_lsb] <= 1'b0;
      r_pend           <= 1'b0;
    end else if (r_state != S_IDLE) begin
      if (!r_phase) begin
        r_phase <= 1'b1;
        r_sclk  <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_sclk  <= 1'b0;
        r_tx    <= {r_tx[30:0], 1'b0};
        r_mosi  <= r_tx[30];
        r_cnt   <= r_cnt + 16'd1;
        if (w_last_bit) begin
          r_cnt <= 16'd0;
          case (r_state)
            S_CMD:  r_state <= S_ADDR;
            S_ADDR: r_state <= S_DATA;
            S_DATA: begin
              r_state         <= S_IDLE;
              r_cs_n          <= 1'b1;
              r_mosi          <= 1'b0;
              r_valid[r_wsel] <= 1'b1;
            end
            default: r_state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // MISO is captured on the edge where sclk rises.
  always_ff @(posedge clk) begin
    if (w_shift_en) begin
      r_buf[r_wsel] <= {spi_miso, r_buf[r_wsel][N-1:1]};
    end
  end

  assign w_col     = hpos >> PIX_SHIFT;
  assign w_bidx    = w_col[CW-1:0];
  assign w_in_view = ({1'b0, hpos} < 11'(H_VIEW)) && (w_col < 10'(N));

  // Registered pixel from the buffer selected by the displayed line's parity.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pixel <= 1'b0;
    end else begin
      r_pixel <= visible && w_in_view && r_valid[vpos[0]] && r_buf[vpos[0]][w_bidx];
    end
  end

  assign spi_cs_n = r_cs_n;
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
  assign pixel    = r_pixel;
  assign busy     = ~r_cs_n;
  assign overrun  = r_overrun;

endmodule
